// File: rtl/mem_pkg.sv
// Shared types and constants for the two-port memory-bus arbiter.
// Also holds the round-robin selection helper.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef logic port_t;

  localparam logic [31:0] ABORT_RDATA = 32'hFFFF_FFFF;

  // On a tie the port that was not granted last wins.
  function automatic port_t pick_port(input logic v0, input logic v1, input port_t last);
    port_t p;
    if (v0 && v1) begin
      p = ~last;
    end else if (v1) begin
      p = 1'b1;
    end else begin
      p = 1'b0;
    end
    return p;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Saturating cycle counter that flags the last cycle a memory access may
// stay outstanding before it has to be aborted.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SAT_CNT  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_r;

  // Count busy cycles, holding at the saturation value instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != SAT_CNT)) begin
      count_r <= count_r + CW'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = enable && (count_r == LAST_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one native memory bus between instruction
// fetch (port 0) and data access (port 1), with a watchdog abort.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m1_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic [3:0]  m1_wstrb,
  output logic        m0_ready,
  output logic        m1_ready,
  output logic [31:0] m_rdata,
  output logic        bus_err,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  arb_state_t state_r;
  port_t      owner_r;
  port_t      last_r;
  port_t      pick_s;
  logic       wd_clear_s;
  logic       wd_enable_s;
  logic       expire_s;

  assign pick_s      = pick_port(m0_valid, m1_valid, last_r);
  assign wd_clear_s  = (state_r == IDLE);
  assign wd_enable_s = (state_r == BUSY);

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clear (wd_clear_s),
    .enable(wd_enable_s),
    .expire(expire_s)
  );

  // Arbitration FSM; every bus and port output is a register of this block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      owner_r   <= 1'b0;
      last_r    <= 1'b1;
      m0_ready  <= 1'b0;
      m1_ready  <= 1'b0;
      m_rdata   <= 32'h0000_0000;
      bus_err   <= 1'b0;
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_wstrb <= 4'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            owner_r   <= pick_s;
            mem_valid <= 1'b1;
            mem_instr <= (pick_s == 1'b0);
            mem_addr  <= pick_s ? m1_addr  : m0_addr;
            mem_wdata <= pick_s ? m1_wdata : m0_wdata;
            mem_wstrb <= pick_s ? m1_wstrb : m0_wstrb;
            state_r   <= BUSY;
          end
        end
        BUSY: begin
          // A response in the expiry cycle still counts as a normal completion.
          if (mem_ready || expire_s) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'h0;
            m_rdata   <= mem_ready ? mem_rdata : ABORT_RDATA;
            bus_err   <= ~mem_ready;
            m0_ready  <= (owner_r == 1'b0);
            m1_ready  <= (owner_r == 1'b1);
            last_r    <= owner_r;
            state_r   <= RESP;
          end
        end
        RESP: begin
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
          bus_err  <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, randomized transfers
// against a transaction-level model, fairness and reset corner cases.
module tb_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0;
  logic [31:0] m0_wdata = 32'h0, m1_wdata = 32'h0;
  logic [3:0]  m0_wstrb = 4'h0, m1_wstrb = 4'h0;
  logic        m0_ready, m1_ready;
  logic [31:0] m_rdata;
  logic        bus_err;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int total = 0;
  int bad = 0;
  logic last_m = 1'b1;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [3:0]  ws0;
    logic [3:0]  ws1;
    int          lat;
    logic [31:0] rd;
    logic        owner;
    logic        err;
  } vec_t;

  vec_t tbl[7];

  mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m1_valid(m1_valid),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_wstrb(m0_wstrb), .m1_wstrb(m1_wstrb),
    .m0_ready(m0_ready), .m1_ready(m1_ready),
    .m_rdata(m_rdata), .bus_err(bus_err),
    .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_outs_zero(input string name);
    check({name, "_ctl"}, {27'h0, mem_valid, mem_instr, m0_ready, m1_ready, bus_err}, 32'h0);
    check({name, "_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
    check({name, "_addr"}, mem_addr, 32'h0);
    check({name, "_wdata"}, mem_wdata, 32'h0);
    check({name, "_rdata"}, m_rdata, 32'h0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
    @(negedge clk);
    check_outs_zero("rst");
    reset = 1'b0;
    last_m = 1'b1;
  endtask

  // One complete transfer from an idle arbiter; memory answers in BUSY cycle v.lat.
  task automatic run_txn(input vec_t v);
    int d;
    logic [31:0] exp_rd;
    d = v.err ? TMO : v.lat;
    exp_rd = v.err ? 32'hFFFF_FFFF : v.rd;
    @(negedge clk);
    m0_valid = v.v0; m0_addr = v.a0; m0_wdata = v.wd0; m0_wstrb = v.ws0;
    m1_valid = v.v1; m1_addr = v.a1; m1_wdata = v.wd1; m1_wstrb = v.ws1;
    for (int c = 1; c <= d; c++) begin
      @(negedge clk);
      check("busy_valid", {31'h0, mem_valid}, 32'h1);
      check("busy_noready", {30'h0, m1_ready, m0_ready}, 32'h0);
      if (c == 1) begin
        check("grant_instr", {31'h0, mem_instr}, {31'h0, ~v.owner});
        check("grant_addr", mem_addr, v.owner ? v.a1 : v.a0);
        check("grant_wdata", mem_wdata, v.owner ? v.wd1 : v.wd0);
        check("grant_wstrb", {28'h0, mem_wstrb}, {28'h0, v.owner ? v.ws1 : v.ws0});
      end
      mem_ready = (c == v.lat);
      mem_rdata = v.rd;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    check("done_ready", {30'h0, m1_ready, m0_ready}, v.owner ? 32'h2 : 32'h1);
    check("done_err", {31'h0, bus_err}, {31'h0, v.err});
    check("done_rdata", m_rdata, exp_rd);
    check("done_memvalid", {27'h0, mem_valid, mem_wstrb}, 32'h0);
    m0_valid = 1'b0; m1_valid = 1'b0;
    @(negedge clk);
    check("resp_clear", {29'h0, bus_err, m1_ready, m0_ready}, 32'h0);
    check("idle_memvalid", {31'h0, mem_valid}, 32'h0);
    last_m = v.owner;
  endtask

  initial begin
    vec_t v;
    int   gport[6];
    int   gcyc[6];
    int   ng;
    logic prev;

    tbl[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 2, 32'h0000_0013, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_0104, 32'h0000_2000, 32'h0, 32'h1122_3344, 4'h0, 4'h3, 1, 32'hAAAA_0001, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_0108, 32'h0000_2004, 32'h0, 32'h5566_7788, 4'h0, 4'hC, 1, 32'hAAAA_0002, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 32'h0, 32'h0000_3000, 32'h0, 32'h0, 4'h0, 4'h0, 9, 32'h1234_5678, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_010C, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1, 32'h0000_0093, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'h0, 32'h0000_3004, 32'h0, 32'h0, 4'h0, 4'h0, 4, 32'hCAFE_0004, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 32'h0000_0110, 32'h0000_3008, 32'h0, 32'h0, 4'h0, 4'h1, 3, 32'hBEEF_0003, 1'b0, 1'b0};

    reset_dut();
    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    // Randomized transfers; owner and abort come from the grant rules alone.
    for (int i = 0; i < 40; i++) begin
      v.v0 = $urandom_range(0, 1);
      v.v1 = $urandom_range(0, 1);
      if (!v.v0 && !v.v1) v.v1 = 1'b1;
      v.a0 = $urandom; v.a1 = $urandom; v.wd0 = $urandom; v.wd1 = $urandom;
      v.ws0 = 4'($urandom); v.ws1 = 4'($urandom);
      v.lat = $urandom_range(1, 6);
      v.rd = $urandom;
      if (v.v0 && v.v1) v.owner = (last_m == 1'b1) ? 1'b0 : 1'b1;
      else v.owner = v.v1;
      v.err = (v.lat > TMO);
      run_txn(v);
    end

    // Fairness with both ports permanently requesting and zero-wait memory.
    reset_dut();
    @(negedge clk);
    m0_valid = 1'b1; m0_addr = 32'h0000_0200; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b1; m1_addr = 32'h0000_0300; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF;
    ng = 0;
    prev = 1'b0;
    for (int cyc = 0; cyc < 60 && ng < 6; cyc++) begin
      @(negedge clk);
      check("ready_excl", {31'h0, m0_ready & m1_ready}, 32'h0);
      if (mem_valid && !prev) begin
        gport[ng] = mem_instr ? 0 : 1;
        gcyc[ng] = cyc;
        if (ng == 1) begin
          check("store_wstrb", {28'h0, mem_wstrb}, 32'hF);
          check("store_wdata", mem_wdata, 32'hDEAD_BEEF);
          check("store_instr", {31'h0, mem_instr}, 32'h0);
        end
        ng++;
      end
      prev = mem_valid;
      mem_ready = mem_valid;
    end
    check("fair_count", ng, 32'd6);
    for (int i = 0; i < ng; i++) begin
      check("fair_port", gport[i], i % 2);
      if (i > 0) check("fair_spacing", gcyc[i] - gcyc[i-1], 32'd3);
    end

    // Asynchronous reset in the middle of a transfer, then a stale mem_ready.
    reset_dut();
    @(negedge clk);
    m1_valid = 1'b1; m1_addr = 32'h0000_4444; m1_wdata = 32'h0; m1_wstrb = 4'h3;
    m0_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", {31'h0, mem_valid}, 32'h1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_outs_zero("async_rst");
    @(negedge clk);
    reset = 1'b0; m1_valid = 1'b0; mem_ready = 1'b1;
    last_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stale_ready", {29'h0, bus_err, m1_ready, m0_ready}, 32'h0);
      check("stale_valid", {31'h0, mem_valid}, 32'h0);
    end
    mem_ready = 1'b0;
    v = '{1'b1, 1'b1, 32'h0000_0500, 32'h0000_0600, 32'h0, 32'h0, 4'h0, 4'h0, 1, 32'h0000_0777, 1'b0, 1'b0};
    run_txn(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
